// File: rtl/datapath_gearbox_pkg.sv
// ---------------------------------------------------------------------------
// datapath_gearbox_pkg
//   Types and width helpers shared by the lane gearbox FIFO and its read pacer.
//   - lane_idx_w(n) : bits needed to index n lanes (at least 1)
//   - lane_cnt_w(n) : bits needed to hold a count 0..n
//   - flag_bit_e    : bit positions of the sticky error flags
// ---------------------------------------------------------------------------
package datapath_gearbox_pkg;

  function automatic int lane_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int lane_cnt_w(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

  typedef enum int unsigned {
    FLAG_OVERFLOW  = 0,
    FLAG_UNDERFLOW = 1,
    FLAG_LEN_ERR   = 2
  } flag_bit_e;

  localparam int unsigned N_FLAGS = 3;

  typedef logic [N_FLAGS-1:0] flags_t;

endpackage : datapath_gearbox_pkg

// File: rtl/datapath_rd_pacer.sv
// ---------------------------------------------------------------------------
// datapath_rd_pacer
//   Free-running divider that paces reads of the gearbox FIFO. The count runs
//   0..CLK_DIV-1 and rd_tick is high for the one cycle the count sits at
//   CLK_DIV-1, after which it wraps to 0. With CLK_DIV=1 rd_tick is always 1.
// Ports
//   clk     : rising-edge clock
//   rstn    : asynchronous active-low reset (count returns to 0)
//   rd_tick : read opportunity strobe, combinational from the registered count
// ---------------------------------------------------------------------------
module datapath_rd_pacer #(
  parameter int CLK_DIV = 30
) (
  input  logic clk,
  input  logic rstn,
  output logic rd_tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: every always_comb output gets a value before any branch, so no
  // path through the block can leave it holding state (no latch).
  always_comb begin
    rd_tick = (cnt_q == CNT_W'(CLK_DIV - 1));
    cnt_d   = rd_tick ? '0 : cnt_q + CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : datapath_rd_pacer

// File: rtl/datapath_gearbox_fifo.sv
// ---------------------------------------------------------------------------
// datapath_gearbox_fifo
//   Lane-granular ring FIFO that accepts 1..IN_LANES lanes per write and
//   delivers exactly OUT_LANES lanes per read, oldest lane in lane 0. Both lane
//   pointers wrap modulo DEPTH_LANES, so a write or read may straddle the wrap.
//   Reads are paced by rd_tick: from datapath_rd_pacer when the macro
//   DATAPATH_GEARBOX_PACER_EN is defined, otherwise rd_tick is tied high and
//   CLK_DIV only takes part in the parameter sanity checks.
// Ports
//   clk, rstn          : clock, asynchronous active-low reset
//   wr, wr_lanes       : write request and number of valid lanes in data_in
//   data_in            : IN_LANES lanes, lane 0 at the LSBs
//   rd, rd_fire        : read request, read accepted this cycle
//   data_out           : registered OUT_LANES lanes, lane 0 (oldest) at LSBs
//   lane_count         : lanes currently stored
//   full/empty/threshold : level flags decoded from lane_count
//   overflow/underflow/len_err : sticky error flags, cleared by flag_clr
// ---------------------------------------------------------------------------
module datapath_gearbox_fifo
  import datapath_gearbox_pkg::*;
#(
  parameter int LANE_W      = 64,
  parameter int IN_LANES    = 2,
  parameter int OUT_LANES   = 3,
  parameter int DEPTH_LANES = 2048,
  parameter int CLK_DIV     = 30,
  parameter int THRESH      = DEPTH_LANES / 2
) (
  input  logic                                  clk,
  input  logic                                  rstn,
  input  logic                                  wr,
  input  logic [lane_cnt_w(IN_LANES)-1:0]       wr_lanes,
  input  logic [IN_LANES*LANE_W-1:0]            data_in,
  input  logic                                  rd,
  output logic                                  rd_fire,
  output logic [OUT_LANES*LANE_W-1:0]           data_out,
  output logic [lane_idx_w(DEPTH_LANES):0]      lane_count,
  output logic                                  full,
  output logic                                  empty,
  output logic                                  threshold,
  output logic                                  overflow,
  output logic                                  underflow,
  output logic                                  len_err,
  input  logic                                  flag_clr
);

  localparam int PTR_W = lane_idx_w(DEPTH_LANES);
  localparam int CNT_W = PTR_W + 1;
  localparam int WL_W  = lane_cnt_w(IN_LANES);
  localparam int MAX_L = (IN_LANES > OUT_LANES) ? IN_LANES : OUT_LANES;

  // Elaboration-time guards on the parameter set.
  if ((DEPTH_LANES & (DEPTH_LANES - 1)) != 0) begin : g_chk_pow2
    $error("DEPTH_LANES must be a power of two");
  end
  if (DEPTH_LANES < 2 * MAX_L) begin : g_chk_depth
    $error("DEPTH_LANES must be at least 2*max(IN_LANES,OUT_LANES)");
  end
  if (CLK_DIV < 1) begin : g_chk_div
    $error("CLK_DIV must be at least 1");
  end

  // -------------------------------------------------------------------------
  // Read pacing
  // -------------------------------------------------------------------------
  logic rd_tick;

`ifdef DATAPATH_GEARBOX_PACER_EN
  datapath_rd_pacer #(
    .CLK_DIV (CLK_DIV)
  ) u_rd_pacer (
    .clk     (clk),
    .rstn    (rstn),
    .rd_tick (rd_tick)
  );
`else
  assign rd_tick = 1'b1;
`endif

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            lane_count_q, lane_count_d;
  logic [OUT_LANES*LANE_W-1:0] data_out_q, data_out_d;
  flags_t                      flags_q, flags_d;

  logic [LANE_W-1:0]           mem [DEPTH_LANES];
  logic [OUT_LANES*LANE_W-1:0] rd_lanes;

  logic wr_len_ok;
  logic wr_acc;
  flags_t flag_set;

  // -------------------------------------------------------------------------
  // Level decode and handshakes
  // -------------------------------------------------------------------------
  always_comb begin
    full      = (lane_count_q > CNT_W'(DEPTH_LANES - IN_LANES));
    empty     = (lane_count_q < CNT_W'(OUT_LANES));
    threshold = (lane_count_q >= CNT_W'(THRESH));
    wr_len_ok = (wr_lanes != '0) && (wr_lanes <= WL_W'(IN_LANES));
    wr_acc    = wr & ~full & wr_len_ok;
    rd_fire   = rd & ~empty & rd_tick;
  end

  // The OUT_LANES oldest lanes, gathered across the wrap point by letting the
  // PTR_W-bit index sum overflow naturally.
  always_comb begin
    rd_lanes = '0;
    for (int i = 0; i < OUT_LANES; i++) begin
      rd_lanes[i*LANE_W +: LANE_W] = mem[rd_ptr_q + PTR_W'(i)];
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d     = wr_ptr_q + (wr_acc ? PTR_W'(wr_lanes) : '0);
    rd_ptr_d     = rd_ptr_q + (rd_fire ? PTR_W'(OUT_LANES) : '0);
    lane_count_d = lane_count_q
                 + (wr_acc  ? CNT_W'(wr_lanes)  : '0)
                 - (rd_fire ? CNT_W'(OUT_LANES) : '0);
    data_out_d   = rd_fire ? rd_lanes : data_out_q;

    flag_set                 = '0;
    flag_set[FLAG_OVERFLOW]  = wr & full;
    flag_set[FLAG_UNDERFLOW] = rd & rd_tick & empty;
    flag_set[FLAG_LEN_ERR]   = wr & ~wr_len_ok;
    // A new error in the clearing cycle survives the clear.
    flags_d = (flag_clr ? '0 : flags_q) | flag_set;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      lane_count_q <= '0;
      data_out_q   <= '0;
      flags_q      <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      lane_count_q <= lane_count_d;
      data_out_q   <= data_out_d;
      flags_q      <= flags_d;
    end
  end

  // NOTE: the ring storage has no reset; pointers and lane_count define which
  // entries are valid, so stale contents are never observable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < IN_LANES; i++) begin
      if (wr_acc && (i < int'(wr_lanes))) begin
        mem[wr_ptr_q + PTR_W'(i)] <= data_in[i*LANE_W +: LANE_W];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign data_out   = data_out_q;
  assign lane_count = lane_count_q;
  assign overflow   = flags_q[FLAG_OVERFLOW];
  assign underflow  = flags_q[FLAG_UNDERFLOW];
  assign len_err    = flags_q[FLAG_LEN_ERR];

endmodule : datapath_gearbox_fifo

// File: tb/tb_datapath_gearbox_fifo.sv
// ---------------------------------------------------------------------------
// tb_datapath_gearbox_fifo
//   Self-checking bench for datapath_gearbox_fifo (LANE_W=64, IN_LANES=2,
//   OUT_LANES=3, DEPTH_LANES=16, CLK_DIV=4, THRESH=8). The reference model is
//   a plain queue of lanes plus three flag bits; read words it predicts are
//   pushed to a scoreboard queue that a separate monitor pops whenever the DUT
//   fires a read. When DATAPATH_GEARBOX_PACER_EN is defined the model expects
//   a read opportunity every CLK_DIV cycles after reset, otherwise every cycle.
// ---------------------------------------------------------------------------
module tb_datapath_gearbox_fifo;

  localparam int LANE_W    = 64;
  localparam int IN_LANES  = 2;
  localparam int OUT_LANES = 3;
  localparam int DEPTH     = 16;
  localparam int CLK_DIV   = 4;
  localparam int THRESH    = 8;
  localparam int DW_IN     = IN_LANES * LANE_W;
  localparam int DW_OUT    = OUT_LANES * LANE_W;
`ifdef DATAPATH_GEARBOX_PACER_EN
  localparam int TICK_DIV  = CLK_DIV;
`else
  localparam int TICK_DIV  = 1;
`endif

  logic              clk      = 1'b0;
  logic              rstn     = 1'b0;
  logic              wr       = 1'b0;
  logic [1:0]        wr_lanes = 2'd0;
  logic [DW_IN-1:0]  data_in  = '0;
  logic              rd       = 1'b0;
  logic              flag_clr = 1'b0;
  logic              rd_fire;
  logic [DW_OUT-1:0] data_out;
  logic [4:0]        lane_count;
  logic              full, empty, threshold, overflow, underflow, len_err;

  datapath_gearbox_fifo #(
    .LANE_W      (LANE_W),
    .IN_LANES    (IN_LANES),
    .OUT_LANES   (OUT_LANES),
    .DEPTH_LANES (DEPTH),
    .CLK_DIV     (CLK_DIV),
    .THRESH      (THRESH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .wr         (wr),
    .wr_lanes   (wr_lanes),
    .data_in    (data_in),
    .rd         (rd),
    .rd_fire    (rd_fire),
    .data_out   (data_out),
    .lane_count (lane_count),
    .full       (full),
    .empty      (empty),
    .threshold  (threshold),
    .overflow   (overflow),
    .underflow  (underflow),
    .len_err    (len_err),
    .flag_clr   (flag_clr)
  );

  always #5 clk = ~clk;

  // Counters and checker
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [DW_OUT-1:0] act,
                       input logic [DW_OUT-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: lanes stored, oldest first
  // -------------------------------------------------------------------------
  logic [LANE_W-1:0] m_lanes[$];
  logic [DW_OUT-1:0] exp_q[$];
  bit                m_ovf, m_udf, m_len;
  int                m_cyc;   // clock edges since reset was released

  function automatic bit m_full();
    return m_lanes.size() > DEPTH - IN_LANES;
  endfunction
  function automatic bit m_empty();
    return m_lanes.size() < OUT_LANES;
  endfunction
  function automatic bit m_tick();
    return (m_cyc % TICK_DIV) == TICK_DIV - 1;
  endfunction

  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      m_lanes.delete();
      exp_q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
      m_len = 1'b0;
      m_cyc = 0;
    end else begin
      bit                bad_len, acc, fire, f_full, f_empty, f_tick;
      logic [DW_OUT-1:0] word;
      f_full  = m_full();
      f_empty = m_empty();
      f_tick  = m_tick();
      bad_len = wr && (wr_lanes == 2'd0 || int'(wr_lanes) > IN_LANES);
      acc     = wr && !f_full && !bad_len;
      fire    = rd && !f_empty && f_tick;
      if (fire) begin
        word = '0;
        for (int i = 0; i < OUT_LANES; i++) word[i*LANE_W +: LANE_W] = m_lanes.pop_front();
        exp_q.push_back(word);
      end
      if (acc) begin
        for (int i = 0; i < int'(wr_lanes); i++) m_lanes.push_back(data_in[i*LANE_W +: LANE_W]);
      end
      if (flag_clr) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
        m_len = 1'b0;
      end
      m_ovf = m_ovf | (wr && f_full);
      m_udf = m_udf | (rd && f_tick && f_empty);
      m_len = m_len | bad_len;
      m_cyc++;
    end
  end

  // -------------------------------------------------------------------------
  // Monitor: status every cycle, scoreboard pop after each DUT read
  // -------------------------------------------------------------------------
  bit                fire_seen = 1'b0;
  logic [DW_OUT-1:0] cur_exp   = '0;

  initial forever begin
    logic [11:0] st_act, st_exp;
    @(negedge clk);
    st_act = {lane_count, full, empty, threshold, overflow, underflow, len_err, rd_fire};
    st_exp = {5'(m_lanes.size()), m_full(), m_empty(), (m_lanes.size() >= THRESH),
              m_ovf, m_udf, m_len, (rd && !m_empty() && m_tick())};
    check("status{cnt,full,empty,thr,ovf,udf,len,fire}", DW_OUT'(st_act), DW_OUT'(st_exp));
    if (!rstn) begin
      fire_seen = 1'b0;
      cur_exp   = '0;
    end else if (fire_seen) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL scoreboard: DUT read with no expected word, data_out %0h", data_out);
      end else begin
        cur_exp = exp_q.pop_front();
      end
    end
    check("data_out", data_out, cur_exp);
    fire_seen = rstn && rd_fire;
  end

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LANE_W-1:0] rand_lane();
    return {$urandom, $urandom};
  endfunction

  task automatic do_write(input int n, input logic [DW_IN-1:0] d);
    wr       = 1'b1;
    wr_lanes = 2'(n);
    data_in  = d;
    step();
    wr       = 1'b0;
  endtask

  task automatic pulse_clr();
    flag_clr = 1'b1;
    step();
    flag_clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [LANE_W-1:0] a0, a1, b0, b1;
    int                wr_pct;

    repeat (3) step();
    check("reset_lane_count", DW_OUT'(lane_count), DW_OUT'(0));
    check("reset_empty_full_thr", DW_OUT'({empty, full, threshold}), DW_OUT'(3'b100));
    check("reset_data_out", data_out, '0);
    rstn = 1'b1;

    // Two-lane write, one-lane write with a junk upper lane, then read.
    a0 = rand_lane(); a1 = rand_lane(); b0 = rand_lane(); b1 = rand_lane();
    do_write(2, {a1, a0});
    do_write(1, {b1, b0});
    check("two_writes_lane_count", DW_OUT'(lane_count), DW_OUT'(3));
    rd = 1'b1;
    repeat (2 * TICK_DIV + 2) step();
    rd = 1'b0;
    check("first_read_word", data_out, {b0, a1, a0});
    check("first_read_then_empty", DW_OUT'({empty, lane_count}), DW_OUT'({1'b1, 5'd0}));

    // Fill with 2-lane writes, no reads.
    for (int k = 1; k <= 8; k++) begin
      do_write(2, {rand_lane(), rand_lane()});
      if (k == 3) check("thr_low_at_6", DW_OUT'(threshold), DW_OUT'(0));
      if (k == 4) check("thr_high_at_8", DW_OUT'(threshold), DW_OUT'(1));
      if (k == 7) check("not_full_at_14", DW_OUT'(full), DW_OUT'(0));
    end
    check("full_at_16", DW_OUT'({full, lane_count}), DW_OUT'({1'b1, 5'd16}));
    do_write(2, {rand_lane(), rand_lane()});
    check("overflow_set_count_held", DW_OUT'({overflow, lane_count}), DW_OUT'({1'b1, 5'd16}));
    pulse_clr();
    check("overflow_cleared", DW_OUT'(overflow), DW_OUT'(0));

    // Drain to a single lane.
    rd = 1'b1;
    repeat (6 * TICK_DIV) step();
    rd = 1'b0;
    check("drained_to_one", DW_OUT'(lane_count), DW_OUT'(1));

    // Write and read on the same edge at lane_count=5.
    do_write(2, {rand_lane(), rand_lane()});
    do_write(2, {rand_lane(), rand_lane()});
    for (int k = 0; k < TICK_DIV && !m_tick(); k++) step();
    wr = 1'b1; wr_lanes = 2'd2; data_in = {rand_lane(), rand_lane()}; rd = 1'b1;
    step();
    wr = 1'b0; rd = 1'b0;
    check("simul_wr_rd_count", DW_OUT'(lane_count), DW_OUT'(4));
    do_write(0, {rand_lane(), rand_lane()});
    check("len_err_zero_lanes", DW_OUT'({len_err, lane_count}), DW_OUT'({1'b1, 5'd4}));
    pulse_clr();

    // Read past empty on a tick.
    rd = 1'b1;
    repeat (2 * TICK_DIV) step();
    check("underflow_set", DW_OUT'({underflow, rd_fire}), DW_OUT'(2'b10));
    rd = 1'b0;
    pulse_clr();
    check("flags_cleared", DW_OUT'({overflow, underflow, len_err}), DW_OUT'(0));

    // Continuous stream of 40 lanes with reads held on, crossing the wrap.
    rd = 1'b1;
    for (int k = 0; k < 20; k++) begin
      do_write(2, {rand_lane(), rand_lane()});
      step();
      step();
    end
    repeat (8 * TICK_DIV) step();
    rd = 1'b0;

    // Randomised traffic with a reset in the middle.
    for (int seg = 0; seg < 8; seg++) begin
      case (seg % 3)
        0:       wr_pct = 30;
        1:       wr_pct = 55;
        default: wr_pct = 90;
      endcase
      for (int k = 0; k < 400; k++) begin
        wr       = ($urandom_range(99) < wr_pct);
        wr_lanes = ($urandom_range(15) == 0) ? 2'($urandom_range(1) * 3) : 2'($urandom_range(2, 1));
        data_in  = {rand_lane(), rand_lane()};
        rd       = ($urandom_range(3) != 0);
        flag_clr = ($urandom_range(31) == 0);
        step();
      end
      if (seg == 4) begin
        rstn = 1'b0;
        step();
        check("midrst_outputs", DW_OUT'({lane_count, empty, full, threshold, rd_fire,
                                          overflow, underflow, len_err}),
              DW_OUT'({5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000}));
        check("midrst_data_out", data_out, '0);
        step();
        rstn = 1'b1;
      end
    end

    // Drain what is left and confirm every predicted read was observed.
    wr = 1'b0; flag_clr = 1'b0; rd = 1'b1;
    repeat (7 * TICK_DIV) step();
    rd = 1'b0;
    repeat (3) step();
    check("scoreboard_drained", DW_OUT'(exp_q.size()), DW_OUT'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_datapath_gearbox_fifo
